// File: rtl/notch_tune_pkg.sv
// Shared types and helpers for the notch filter trim-code tuning sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t    - sequencer FSM state encoding
//   mid_code() - mid-scale trim code for a given code width
//   acc_width()- accumulator width that can hold 2^avg_log2 full-scale samples
package notch_tune_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        REQ    = 3'd3,
        ACCUM  = 3'd4,
        EVAL   = 3'd5,
        FINISH = 3'd6
    } state_t;

    // Mid-scale code: only the MSB set.
    function automatic int mid_code(input int code_w);
        return 1 << (code_w - 1);
    endfunction

    // Summing 2^avg_log2 samples of mag_w bits needs avg_log2 extra bits.
    function automatic int acc_width(input int mag_w, input int avg_log2);
        return mag_w + avg_log2;
    endfunction

endpackage

// File: rtl/notch_mag_avg.sv
// Magnitude sample accumulator: sums 2^AVG_LOG2 detector samples and exposes their mean.
// Latency: a sample is absorbed on the clock it is valid; avg/last_sample reflect it one cycle later.
// Backpressure: none; every sample_vld cycle is consumed, clear has priority over a sample.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   clear        - zero the accumulator and sample count
//   sample_vld   - sample_dat is to be accumulated this cycle
//   sample_dat   - unsigned magnitude sample
//   last_sample  - all 2^AVG_LOG2 samples of the current code have been absorbed
//   avg          - accumulated sum >> AVG_LOG2 (truncated)
module notch_mag_avg
    import notch_tune_pkg::*;
#(
    parameter int MAG_W    = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_vld,
    input  logic [MAG_W-1:0] sample_dat,
    output logic             last_sample,
    output logic [MAG_W-1:0] avg
);

    localparam int ACC_W = acc_width(MAG_W, AVG_LOG2);
    // One extra bit so the count can reach 2^AVG_LOG2 itself (also keeps
    // the width non-zero when AVG_LOG2 = 0).
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] N_SAMP = CNT_W'(1) << AVG_LOG2;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (sample_vld) begin
            acc <= acc + ACC_W'(sample_dat);
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Counting accepted samples (rather than "samples still to go") means the
    // controller just asks "is the set complete?" after each accumulate.
    assign last_sample = (cnt == N_SAMP);

    // The sum of N samples shifted down by log2(N) always fits MAG_W bits.
    assign avg = MAG_W'(acc >> AVG_LOG2);

endmodule

// File: rtl/notch_tune_ctrl.sv
// Trim-code sweep sequencer for the active notch filter C1 capacitor bank; applies the deepest-notch code.
// Latency: per code 1 + SETTLE_CYC + 2*2^AVG_LOG2 + 1 cycles with zero-wait acks, plus 1 FINISH cycle.
// Backpressure: mag_req is held until mag_ack; start is ignored while busy; abort wins over every transition.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start               - one-cycle pulse, starts a sweep from IDLE
//   abort               - level, ends a sweep and restores the pre-sweep best code
//   code_out, code_upd  - trim code to the capacitor bank and its change strobe
//   mag_req             - magnitude sample request, held until mag_ack
//   mag_ack, mag_data   - detector acknowledge with same-cycle sample
//   busy, done          - sweep in progress / best code applied (pulse)
//   best_code, best_mag - code with the lowest averaged magnitude and that magnitude
// Optional build macro NOTCH_TUNE_DEPTH_CHECK_EN adds depth_thr (in) and
// tune_fail (out): tune_fail flags a final best_mag above depth_thr.
module notch_tune_ctrl
    import notch_tune_pkg::*;
#(
    parameter int CODE_W     = 6,
    parameter int MAG_W      = 12,
    parameter int SETTLE_CYC = 64,
    parameter int AVG_LOG2   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [CODE_W-1:0] code_out,
    output logic              code_upd,
    output logic              mag_req,
    input  logic              mag_ack,
    input  logic [MAG_W-1:0]  mag_data,
    output logic              busy,
    output logic              done,
    output logic [CODE_W-1:0] best_code,
    output logic [MAG_W-1:0]  best_mag
`ifdef NOTCH_TUNE_DEPTH_CHECK_EN
    ,
    input  logic [MAG_W-1:0]  depth_thr,
    output logic              tune_fail
`endif
);

    localparam logic [CODE_W-1:0] MID_CODE = CODE_W'(mid_code(CODE_W));
    // Wide enough to hold SETTLE_CYC-1 even when SETTLE_CYC = 1.
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);

    state_t            state;
    logic [CODE_W-1:0] scan_code;    // code currently under test
    logic [CODE_W-1:0] shadow_code;  // best_code captured at start, restored on abort
    logic [SET_W-1:0]  settle_cnt;

    logic              avg_clear;
    logic              avg_vld;
    logic              avg_last;
    logic [MAG_W-1:0]  avg;
    logic              abort_hit;

    // abort only matters once a sweep is running.
    assign abort_hit = abort && (state != IDLE);

    // A sample counts only on a genuine handshake in REQ; a stray ack while
    // mag_req is low, or one coinciding with abort, is dropped.
    assign avg_vld   = (state == REQ) && mag_req && mag_ack && !abort_hit;
    assign avg_clear = ((state == IDLE) && start) || (state == EVAL);

    notch_mag_avg #(
        .MAG_W    (MAG_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_mag_avg (
        .clk         (clk),
        .rst         (rst),
        .clear       (avg_clear),
        .sample_vld  (avg_vld),
        .sample_dat  (mag_data),
        .last_sample (avg_last),
        .avg         (avg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            scan_code   <= '0;
            shadow_code <= MID_CODE;
            settle_cnt  <= '0;
            code_out    <= MID_CODE;
            code_upd    <= 1'b0;
            mag_req     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            best_code   <= MID_CODE;
            best_mag    <= '1;
`ifdef NOTCH_TUNE_DEPTH_CHECK_EN
            tune_fail   <= 1'b0;
`endif
        end else begin
            // Strobes default low; the states below raise them for one cycle.
            code_upd <= 1'b0;
            done     <= 1'b0;

            if (abort_hit) begin
                // Return the bank to what it was before this sweep; the
                // partially swept results are not trusted.
                state    <= IDLE;
                busy     <= 1'b0;
                mag_req  <= 1'b0;
                code_out <= shadow_code;
                code_upd <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            best_mag    <= '1;
                            scan_code   <= '0;
                            shadow_code <= best_code;
                            busy        <= 1'b1;
                            state       <= APPLY;
`ifdef NOTCH_TUNE_DEPTH_CHECK_EN
                            tune_fail   <= 1'b0;
`endif
                        end
                    end

                    APPLY: begin
                        code_out   <= scan_code;
                        code_upd   <= 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end

                    SETTLE: begin
                        // Counter loaded with SETTLE_CYC-1 and exits on 0,
                        // so exactly SETTLE_CYC cycles are spent here.
                        if (settle_cnt == '0) begin
                            mag_req <= 1'b1;
                            state   <= REQ;
                        end else begin
                            settle_cnt <= settle_cnt - SET_W'(1);
                        end
                    end

                    REQ: begin
                        if (mag_req && mag_ack) begin
                            mag_req <= 1'b0;
                            state   <= ACCUM;
                        end
                    end

                    ACCUM: begin
                        if (avg_last) begin
                            state <= EVAL;
                        end else begin
                            mag_req <= 1'b1;
                            state   <= REQ;
                        end
                    end

                    EVAL: begin
                        // Strict compare: on a tie the earlier (lower) code stays.
                        if (avg < best_mag) begin
                            best_mag  <= avg;
                            best_code <= scan_code;
                        end
                        if (scan_code == '1) begin
                            state <= FINISH;
                        end else begin
                            scan_code <= scan_code + CODE_W'(1);
                            state     <= APPLY;
                        end
                    end

                    FINISH: begin
                        code_out <= best_code;
                        code_upd <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
`ifdef NOTCH_TUNE_DEPTH_CHECK_EN
                        // best_mag was settled by the last EVAL one cycle ago.
                        tune_fail <= (best_mag > depth_thr);
`endif
                    end

                    default: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        mag_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_notch_tune_ctrl.sv
// Self-checking bench for notch_tune_ctrl with a small configuration
// (CODE_W=3, SETTLE_CYC=4, AVG_LOG2=1) and a behavioural detector model.
module tb_notch_tune_ctrl;

    localparam int CODE_W     = 3;
    localparam int MAG_W      = 12;
    localparam int SETTLE_CYC = 4;
    localparam int AVG_LOG2   = 1;
    localparam int NC         = 1 << CODE_W;
    localparam int NS         = 1 << AVG_LOG2;
    localparam int MID        = 1 << (CODE_W - 1);
    localparam int ALL1       = (1 << MAG_W) - 1;
    localparam int SWEEP_CYC  = NC * (1 + SETTLE_CYC + 2 * NS + 1) + 1;
    localparam int BUDGET     = 5000;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [CODE_W-1:0] code_out;
    logic              code_upd;
    logic              mag_req;
    logic              mag_ack;
    logic [MAG_W-1:0]  mag_data;
    logic              busy;
    logic              done;
    logic [CODE_W-1:0] best_code;
    logic [MAG_W-1:0]  best_mag;
`ifdef NOTCH_TUNE_DEPTH_CHECK_EN
    logic [MAG_W-1:0]  depth_thr;
    logic              tune_fail;
`endif

    notch_tune_ctrl #(
        .CODE_W     (CODE_W),
        .MAG_W      (MAG_W),
        .SETTLE_CYC (SETTLE_CYC),
        .AVG_LOG2   (AVG_LOG2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .code_out  (code_out),
        .code_upd  (code_upd),
        .mag_req   (mag_req),
        .mag_ack   (mag_ack),
        .mag_data  (mag_data),
        .busy      (busy),
        .done      (done),
        .best_code (best_code),
        .best_mag  (best_mag)
`ifdef NOTCH_TUNE_DEPTH_CHECK_EN
        ,
        .depth_thr (depth_thr),
        .tune_fail (tune_fail)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Detector model: per-code sample table, random ack latency, optional stray acks.
    logic [MAG_W-1:0] tbl [NC][NS];
    int ack_cnt [NC];
    int max_lat = 0;
    bit spur_en = 1'b0;
    int req_drop_err = 0;
    int done_cnt = 0;
    int sidx = 0;
    int lat_left = -1;

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        mag_ack  = 1'b0;
        mag_data = '0;
        forever begin
            @(negedge clk);
            mag_ack  = 1'b0;
            mag_data = '0;
            if (code_upd) sidx = 0;
            if (rst) begin
                lat_left = -1;
            end else if (mag_req) begin
                if (lat_left < 0) lat_left = (max_lat == 0) ? 0 : $urandom_range(0, max_lat);
                if (lat_left == 0) begin
                    mag_ack  = 1'b1;
                    mag_data = (sidx < NS) ? tbl[code_out][sidx] : MAG_W'(ALL1);
                    sidx++;
                    ack_cnt[code_out]++;
                    lat_left = -1;
                end else begin
                    lat_left--;
                end
            end else begin
                if (lat_left >= 0) req_drop_err++;
                lat_left = -1;
                if (spur_en && $urandom_range(0, 3) == 0) begin
                    mag_ack  = 1'b1;
                    mag_data = '0;
                end
            end
        end
    end

    // Reference: mean of each code's samples (truncated), first strict minimum wins.
    task automatic ref_best(output int bc, output int bm);
        bm = ALL1;
        bc = -1;
        for (int c = 0; c < NC; c++) begin
            int s = 0;
            for (int k = 0; k < NS; k++) s += int'(tbl[c][k]);
            s = s / NS;
            if (s < bm) begin
                bm = s;
                bc = c;
            end
        end
    endtask

    task automatic run_sweep(output int lat, output bit ok);
        int cyc;
        for (int c = 0; c < NC; c++) ack_cnt[c] = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        lat = cyc;
        ok  = done;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (code_out !== MID)  begin errors++; $display("FAIL reset_code_out got %0d exp %0d", code_out, MID); end
        checks++; if (best_code !== MID) begin errors++; $display("FAIL reset_best_code got %0d exp %0d", best_code, MID); end
        checks++; if (best_mag !== ALL1) begin errors++; $display("FAIL reset_best_mag got %0d exp %0d", best_mag, ALL1); end
        checks++; if ({busy, done, mag_req, code_upd} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {busy, done, mag_req, code_upd}); end
        rst = 1'b0;
        // Start a sweep and hit reset while settling on code 0.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1 || code_out !== 0) begin errors++; $display("FAIL settle_pre busy=%b code=%0d exp busy=1 code=0", busy, code_out); end
        #2 rst = 1'b1;
        #1;
        checks++; if (code_out !== MID) begin errors++; $display("FAIL midreset_code_out got %0d exp %0d", code_out, MID); end
        checks++; if (busy !== 1'b0 || mag_req !== 1'b0) begin errors++; $display("FAIL midreset_busy_req got %b%b exp 00", busy, mag_req); end
        checks++; if (best_mag !== ALL1) begin errors++; $display("FAIL midreset_best_mag got %0d exp %0d", best_mag, ALL1); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_sweep();
        int bc, bm, lat, bad;
        bit ok;
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < NS; k++) tbl[c][k] = MAG_W'(((c > 5) ? (c - 5) : (5 - c)) * 100);
        max_lat = 0; spur_en = 1'b0;
        ref_best(bc, bm);
        run_sweep(lat, ok);
        checks++; if (!ok || lat != SWEEP_CYC) begin errors++; $display("FAIL sweep_latency got %0d (done=%0d) exp %0d", lat, ok, SWEEP_CYC); end
        checks++; if (best_code !== bc) begin errors++; $display("FAIL sweep_best_code got %0d exp %0d", best_code, bc); end
        checks++; if (best_mag !== bm)  begin errors++; $display("FAIL sweep_best_mag got %0d exp %0d", best_mag, bm); end
        checks++; if (code_out !== bc)  begin errors++; $display("FAIL sweep_code_out got %0d exp %0d", code_out, bc); end
        checks++; if (done_cnt != 1)    begin errors++; $display("FAIL sweep_done_pulses got %0d exp 1", done_cnt); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL sweep_busy_after got %b exp 0", busy); end
        bad = 0;
        for (int c = 0; c < NC; c++) if (ack_cnt[c] != NS) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL sweep_acks codes_wrong %0d exp 0", bad); end
    endtask

    task automatic test_avg_tie();
        int bc, bm, lat;
        bit ok;
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < NS; k++) tbl[c][k] = MAG_W'(ALL1);
        tbl[2][0] = 10; tbl[2][1] = 13;
        tbl[4][0] = 11; tbl[4][1] = 12;
        ref_best(bc, bm);
        run_sweep(lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tie_done got 0 exp 1"); end
        checks++; if (best_code !== bc || code_out !== bc) begin errors++; $display("FAIL tie_best_code got %0d/%0d exp %0d", best_code, code_out, bc); end
        checks++; if (best_mag !== bm) begin errors++; $display("FAIL tie_best_mag got %0d exp %0d", best_mag, bm); end
    endtask

    int rnd_code, rnd_mag;

    task automatic test_random();
        int bc, bm, lat;
        bit ok;
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < NS; k++) tbl[c][k] = MAG_W'($urandom_range(0, 4000));
        max_lat = 0; spur_en = 1'b0;
        ref_best(bc, bm);
        run_sweep(lat, ok);
        rnd_code = int'(best_code);
        rnd_mag  = int'(best_mag);
        checks++; if (!ok || lat != SWEEP_CYC) begin errors++; $display("FAIL rand_latency got %0d exp %0d", lat, SWEEP_CYC); end
        checks++; if (best_code !== bc || code_out !== bc) begin errors++; $display("FAIL rand_best_code got %0d/%0d exp %0d", best_code, code_out, bc); end
        checks++; if (best_mag !== bm) begin errors++; $display("FAIL rand_best_mag got %0d exp %0d", best_mag, bm); end
    endtask

    // Same table as test_random, now with 0..7 cycle ack latency and stray acks.
    task automatic test_ack_latency();
        int bc, bm, lat, bad;
        bit ok;
        max_lat = 7; spur_en = 1'b1; req_drop_err = 0;
        ref_best(bc, bm);
        run_sweep(lat, ok);
        max_lat = 0; spur_en = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL lat_done got 0 exp 1"); end
        checks++; if (best_code !== bc || best_code !== rnd_code) begin errors++; $display("FAIL lat_best_code got %0d exp %0d (immediate run %0d)", best_code, bc, rnd_code); end
        checks++; if (best_mag !== bm || best_mag !== rnd_mag) begin errors++; $display("FAIL lat_best_mag got %0d exp %0d (immediate run %0d)", best_mag, bm, rnd_mag); end
        checks++; if (req_drop_err != 0) begin errors++; $display("FAIL lat_req_held drops %0d exp 0", req_drop_err); end
        bad = 0;
        for (int c = 0; c < NC; c++) if (ack_cnt[c] != NS) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL lat_acks codes_wrong %0d exp 0", bad); end
    endtask

    task automatic test_abort();
        int bc, bm, lat, n;
        bit ok;
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < NS; k++) tbl[c][k] = MAG_W'(((c > 3) ? (c - 3) : (3 - c)) * 10 + 5);
        ref_best(bc, bm);
        run_sweep(lat, ok);
        checks++; if (best_code !== bc) begin errors++; $display("FAIL abort_prior_best got %0d exp %0d", best_code, bc); end
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < NS; k++) tbl[c][k] = MAG_W'(((c > 6) ? (c - 6) : (6 - c)) * 10);
        done_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(busy && code_out == 2) && n < BUDGET) begin @(negedge clk); n++; end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || code_out !== 2) begin errors++; $display("FAIL start_while_busy busy=%b code=%0d exp busy=1 code=2", busy, code_out); end
        n = 0;
        while (!(mag_req && code_out == 4) && n < BUDGET) begin @(negedge clk); n++; end
        checks++; if (n >= BUDGET) begin errors++; $display("FAIL abort_reach_req4 waited %0d cycles limit %0d", n, BUDGET); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++; if (busy !== 1'b0 || mag_req !== 1'b0) begin errors++; $display("FAIL abort_idle busy=%b req=%b exp 0 0", busy, mag_req); end
        checks++; if (code_out !== bc || code_upd !== 1'b1) begin errors++; $display("FAIL abort_restore code=%0d upd=%b exp code=%0d upd=1", code_out, code_upd, bc); end
        repeat (100) @(negedge clk);
        checks++; if (done_cnt != 0 || busy !== 1'b0 || code_out !== bc) begin errors++; $display("FAIL abort_after done=%0d busy=%b code=%0d exp 0 0 %0d", done_cnt, busy, code_out, bc); end
    endtask

`ifdef NOTCH_TUNE_DEPTH_CHECK_EN
    task automatic test_depth_check();
        int lat, pos;
        bit ok;
        depth_thr = 50;
        pos = $urandom_range(0, NC - 1);
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < NS; k++) tbl[c][k] = (c == pos) ? MAG_W'(80) : MAG_W'(200);
        run_sweep(lat, ok);
        checks++; if (tune_fail !== 1'b1) begin errors++; $display("FAIL depth_shallow tune_fail got %b exp 1", tune_fail); end
        checks++; if (code_out !== pos) begin errors++; $display("FAIL depth_shallow_code got %0d exp %0d", code_out, pos); end
        pos = $urandom_range(0, NC - 1);
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < NS; k++) tbl[c][k] = (c == pos) ? MAG_W'(20) : MAG_W'(200);
        run_sweep(lat, ok);
        checks++; if (tune_fail !== 1'b0) begin errors++; $display("FAIL depth_deep tune_fail got %b exp 0", tune_fail); end
        checks++; if (code_out !== pos) begin errors++; $display("FAIL depth_deep_code got %0d exp %0d", code_out, pos); end
    endtask
`endif

    initial begin
`ifdef NOTCH_TUNE_DEPTH_CHECK_EN
        depth_thr = '0;
`endif
        test_reset();
        test_full_sweep();
        test_avg_tie();
        test_random();
        test_ack_latency();
        test_abort();
`ifdef NOTCH_TUNE_DEPTH_CHECK_EN
        test_depth_check();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
